// File: rtl/jt51_timer_regs.sv
// jt51_timer_regs: CPU write interface for the YM2151 timers.
// This block holds the timer start values and the timer control bits.
// It also tracks the write-busy flag and builds the status byte.
// Optional macro JT51_CSM_EN enables CSM key-on generation from timer A overflow.
// When the macro is undefined, csm_kon is tied to 0 and din[7] at 0x14 is ignored.
module jt51_timer_regs #(
    parameter int BUSY_LEN = 32
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       zero,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    input  logic       flag_A,
    input  logic       flag_B,
    input  logic       overflow_A,
    output logic [7:0] dout,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       busy,
    output logic       csm_kon
);

    logic       strobe, strobe_l, wr_edge, addr_wr, data_wr;
    logic [7:0] addr;
    logic [7:0] busy_cnt;

    assign strobe  = !cs_n && !wr_n;
    assign wr_edge = strobe && !strobe_l;
    assign addr_wr = wr_edge && !a0;
    assign data_wr = wr_edge && a0;

    // Remember the previous strobe level so that a held strobe produces only one write.
    always_ff @(posedge clk) begin
        if (rst) strobe_l <= 1'b0;
        else     strobe_l <= strobe;
    end

    // Address latch and register file. The clr_flag outputs are one-clk pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr         <= 8'd0;
            value_A      <= 10'd0;
            value_B      <= 8'd0;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
        end else begin
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            if (addr_wr) addr <= din;
            if (data_wr) begin
                case (addr)
                    8'h10: value_A[9:2] <= din;
                    8'h11: value_A[1:0] <= din[1:0];
                    8'h12: value_B      <= din;
                    8'h14: begin
                        enable_irq_B <= din[3];
                        enable_irq_A <= din[2];
                        load_B       <= din[1];
                        load_A       <= din[0];
                        clr_flag_B   <= din[5];
                        clr_flag_A   <= din[4];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Busy window. A data write (re)starts the window.
    // The cen that finds the counter at 0 ends it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            busy_cnt <= 8'd0;
        end else if (data_wr) begin
            busy     <= 1'b1;
            busy_cnt <= 8'(BUSY_LEN - 1);
        end else if (cen && busy) begin
            if (busy_cnt == 8'd0) busy <= 1'b0;
            else                  busy_cnt <= busy_cnt - 8'd1;
        end
    end

    // Register the status byte every clk, regardless of chip select.
    always_ff @(posedge clk) begin
        if (rst) dout <= 8'd0;
        else     dout <= {busy, 5'b0, flag_B, flag_A};
    end

`ifdef JT51_CSM_EN
    logic       csm_en;
    logic [4:0] csm_cnt;
    logic       csm_off;

    // A 0x14 write with bit 7 clear shuts CSM down. This wins over a trigger on the same clk.
    assign csm_off = data_wr && addr == 8'h14 && !din[7];

    // CSM key-on: a timer A overflow in slot 0 holds key-on for 32 cen cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            csm_en  <= 1'b0;
            csm_kon <= 1'b0;
            csm_cnt <= 5'd0;
        end else begin
            if (data_wr && addr == 8'h14) csm_en <= din[7];
            if (csm_off) begin
                csm_kon <= 1'b0;
                csm_cnt <= 5'd0;
            end else if (cen && zero && overflow_A && csm_en) begin
                csm_kon <= 1'b1;
                csm_cnt <= 5'd31;
            end else if (cen && csm_kon) begin
                if (csm_cnt == 5'd0) csm_kon <= 1'b0;
                else                 csm_cnt <= csm_cnt - 5'd1;
            end
        end
    end
`else
    logic unused_csm;
    assign unused_csm = &{1'b0, zero, overflow_A};
    assign csm_kon    = 1'b0;
`endif

endmodule

// File: doc/jt51_timer_regs.md
JT51_TIMER_REGS -- requirements
Module: jt51_timer_regs

Interface
- REQ-001: The block SHALL have parameter BUSY_LEN, default 32, giving the number of cen pulses busy stays high after a data write (legal range 1..255).
- REQ-002: The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
- REQ-003: The block SHALL have port clk, input, 1 bit, the only clock; all logic is on posedge clk.
- REQ-004: The block SHALL have port cen, input, 1 bit, clock enable for the busy and CSM counters.
- REQ-005: The block SHALL have port zero, input, 1 bit, marking the slot-0 cen cycle.
- REQ-006: The block SHALL have ports cs_n, wr_n and a0, inputs, 1 bit each: chip select, write strobe, and address (0) / data (1) select.
- REQ-007: The block SHALL have port din, input, 8 bits, CPU write data.
- REQ-008: The block SHALL have ports flag_A, flag_B and overflow_A, inputs, 1 bit each, coming from the timers block.
- REQ-009: The block SHALL have port dout, output, 8 bits, status byte.
- REQ-010: The block SHALL have ports value_A (10 bits) and value_B (8 bits), outputs, carrying the timer start values.
- REQ-011: The block SHALL have ports load_A, load_B, enable_irq_A and enable_irq_B, outputs, 1 bit each, as level controls.
- REQ-012: The block SHALL have ports clr_flag_A and clr_flag_B, outputs, 1 bit each, as one-clk flag-reset pulses.
- REQ-013: The block SHALL have ports busy and csm_kon, outputs, 1 bit each: write-busy flag and CSM key-on request.

Function
- REQ-014: The block SHALL detect a write when (!cs_n && !wr_n) is high in the current clk and was low in the previous clk; the strobe held low gives exactly one write.
- REQ-015: On a write with a0=0, the block SHALL load din into the 8-bit address latch at that clk edge.
- REQ-016: On a write with a0=1, the block SHALL decode the latched address, and the outputs SHALL update at that same edge.
- REQ-017: Address 0x10 SHALL write value_A[9:2]=din.
- REQ-018: Address 0x11 SHALL write value_A[1:0]=din[1:0].
- REQ-019: Address 0x12 SHALL write value_B=din.
- REQ-020: Address 0x14 SHALL set csm_en=din[7], enable_irq_B=din[3], enable_irq_A=din[2], load_B=din[1] and load_A=din[0].
- REQ-021: Address 0x14 SHALL also pulse clr_flag_B and clr_flag_A high for exactly one clk when din[5] and din[4] are set, respectively.
- REQ-022: Data writes to any other address SHALL change no register but SHALL still start busy.
- REQ-023: Every data write SHALL set busy=1 and load the busy counter with BUSY_LEN-1. On each cen, the counter SHALL decrement, and a cen with the counter at 0 SHALL clear busy. A data write while busy SHALL be accepted and SHALL restart the count.
- REQ-024: Address writes SHALL never affect busy.
- REQ-025: dout SHALL be registered every clk as {busy, 5'b0, flag_B, flag_A}, independent of cs_n.
- REQ-026: CSM trigger: on a clk with cen && zero && overflow_A && csm_en, csm_kon SHALL go to 1 and the 5-bit CSM counter SHALL load 31.
- REQ-027: CSM counter: on each later cen it SHALL decrement, and a cen at 0 SHALL clear csm_kon, giving 32 cen cycles total. A retrigger while active SHALL reload 31.
- REQ-028: A data write clearing csm_en SHALL clear csm_kon and the CSM counter at the same edge, and SHALL take priority over a simultaneous trigger.

Reset
- REQ-029: While rst=1, the address latch, value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B, csm_en, csm_kon, busy, both counters and dout SHALL be 0.
- REQ-030: Reset asserted mid-write or mid-busy SHALL abort the operation, and the write-edge detector SHALL reset to "strobe low".
- REQ-031: A write strobe still low when rst drops SHALL then be taken as a new write.

Configuration
- REQ-032: With macro JT51_CSM_EN defined, the CSM logic SHALL be implemented as in REQ-026 to REQ-028.
- REQ-033: Without JT51_CSM_EN, csm_kon SHALL be constant 0, the CSM counter SHALL be absent, and din[7] at 0x14 SHALL be ignored; all other behaviour SHALL be unchanged.

Verification
- REQ-034: Write addr 0x10 data 0xAB, then addr 0x11 data 0x03 -> value_A=0x2AF; busy high for exactly 32 cen pulses after each data write.
- REQ-035: Write 0x14 with data 0x35 -> load_A=1, load_B=0, enable_irq_A=1, clr_flag_A and clr_flag_B each high for one clk, dout[7]=1.
- REQ-036: Hold cs_n=wr_n=0 for 10 clks with a0=1 -> exactly one register update and one busy start; a second write 5 cen after the first -> busy stays high until 32 cen after the second write.
- REQ-037: JT51_CSM_EN defined, 0x14=0x80, overflow_A with cen&&zero -> csm_kon high for 32 cen. Retrigger at cen 20 -> 32 more cen. Write 0x14=0x00 on the same clk as a trigger -> csm_kon stays 0.
- REQ-038: Assert rst mid-busy with value_B=0x55 -> all outputs 0 the next clk; JT51_CSM_EN undefined, 0x14=0x80 plus overflow_A -> csm_kon stays 0.
